// File: rtl/ofdm_mapper_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_mapper_pkg
// Shared definitions for the OFDM symbol mapper:
//   BITS_QPSK / BITS_QAM16 - legal bits-per-symbol values
//   IQ_W_DFLT / N_SC_DFLT  - default I/Q width and subcarriers per frame
//   sym_t                  - queued symbol record {i, q, idx} at default widths
//   gray_level()           - 16-QAM Gray level for one axis, in units of U
// ---------------------------------------------------------------------------
package ofdm_mapper_pkg;

  localparam int BITS_QPSK  = 2;
  localparam int BITS_QAM16 = 4;

  localparam int IQ_W_DFLT  = 8;
  localparam int N_SC_DFLT  = 48;
  localparam int IDX_W_DFLT = $clog2(N_SC_DFLT);

  typedef struct packed {
    logic signed [IQ_W_DFLT-1:0] i;
    logic signed [IQ_W_DFLT-1:0] q;
    logic        [IDX_W_DFLT-1:0] idx;
  } sym_t;

  // Gray order along one axis: 00 -> +3, 01 -> +1, 11 -> -1, 10 -> -3
  function automatic int gray_level(input logic x1, input logic x0);
    int lvl;
    case ({x1, x0})
      2'b00:   lvl = 3;
      2'b01:   lvl = 1;
      2'b11:   lvl = -1;
      default: lvl = -3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ofdm_sym_fifo.sv
// ---------------------------------------------------------------------------
// ofdm_sym_fifo
// Single-clock first-word-fall-through FIFO for mapped symbols. The head
// entry is presented on head_data whenever empty is low.
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset (pointers only)
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry this cycle (ignored when empty)
//   head_data  out  oldest entry
//   full       out  DEPTH entries held
//   empty      out  no entries held
// ---------------------------------------------------------------------------
module ofdm_sym_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
    $error("ofdm_sym_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB on each pointer separates the full and empty cases
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/ofdm_symbol_mapper.sv
// ---------------------------------------------------------------------------
// ofdm_symbol_mapper
// Collects the LSB-first serial cipher stream into BITS_PER_SYM-bit groups,
// Gray-maps each group to signed I/Q (QPSK or 16-QAM), tags it with its
// subcarrier index and queues it in a small FWFT FIFO towards the IFFT.
// Ports:
//   ofdm_clk        in   clock
//   resetn          in   asynchronous active-low reset
//   ofdm_sdata_vld  in   serial bit valid
//   ofdm_sdata_rdy  out  mapper accepts a bit this cycle
//   ofdm_sdata      in   serial cipher bit
//   sym_vld         out  symbol valid
//   sym_rdy         in   downstream accepts the symbol
//   sym_i / sym_q   out  signed in-phase / quadrature value
//   sym_idx         out  subcarrier index 0..N_SC-1
//   sym_sof         out  first subcarrier of the frame
//   sym_eof         out  last subcarrier of the frame
// ---------------------------------------------------------------------------
module ofdm_symbol_mapper
  import ofdm_mapper_pkg::*;
#(
  parameter int BITS_PER_SYM = BITS_QPSK,
  parameter int N_SC         = N_SC_DFLT,
  parameter int IQ_W         = IQ_W_DFLT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     ofdm_clk,
  input  logic                     resetn,
  input  logic                     ofdm_sdata_vld,
  output logic                     ofdm_sdata_rdy,
  input  logic                     ofdm_sdata,
  output logic                     sym_vld,
  input  logic                     sym_rdy,
  output logic signed [IQ_W-1:0]   sym_i,
  output logic signed [IQ_W-1:0]   sym_q,
  output logic [$clog2(N_SC)-1:0]  sym_idx,
  output logic                     sym_sof,
  output logic                     sym_eof
);

  localparam int IDX_W  = $clog2(N_SC);
  localparam int BC_W   = $clog2(BITS_PER_SYM);
  localparam int SYM_W  = 2 * IQ_W + IDX_W;
  localparam int A_QPSK = 1 << (IQ_W - 2);
  localparam int U_QAM  = 1 << (IQ_W - 3);

  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(BITS_PER_SYM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SC - 1);

  if ((BITS_PER_SYM != BITS_QPSK) && (BITS_PER_SYM != BITS_QAM16)) begin : g_bad_bits
    $error("ofdm_symbol_mapper: BITS_PER_SYM must be 2 or 4");
  end

  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
    logic [IDX_W-1:0]       idx;
  } sym_word_t;

  logic [BITS_PER_SYM-1:0] bits_p0;
  logic [BC_W-1:0]         bit_cnt_p0;
  logic [IDX_W-1:0]        sym_cnt_p0;
  logic [BITS_PER_SYM-1:0] sym_bits;
  logic                    bit_acc;
  logic                    push_vld_p0;
  logic signed [IQ_W-1:0]  map_i;
  logic signed [IQ_W-1:0]  map_q;
  sym_word_t               push_word;
  sym_word_t               head_word;
  logic [SYM_W-1:0]        head_data;
  logic                    fifo_full;
  logic                    fifo_empty;

  // ---- stage p0: bit assembly and Gray mapping ----

  // Only the completing bit needs FIFO room; earlier bits of a symbol are
  // always taken. Deliberately independent of sym_rdy.
  assign ofdm_sdata_rdy = !fifo_full || (bit_cnt_p0 != LAST_BIT);
  assign bit_acc        = ofdm_sdata_vld && ofdm_sdata_rdy;
  assign push_vld_p0    = bit_acc && (bit_cnt_p0 == LAST_BIT);

  // Current group with the incoming bit merged in, so the completing bit
  // maps straight into the FIFO without an extra register stage.
  always_comb begin
    sym_bits             = bits_p0;
    sym_bits[bit_cnt_p0] = ofdm_sdata;
  end

  if (BITS_PER_SYM == BITS_QAM16) begin : g_qam16
    assign map_i = IQ_W'(gray_level(sym_bits[1], sym_bits[0]) * U_QAM);
    assign map_q = IQ_W'(gray_level(sym_bits[3], sym_bits[2]) * U_QAM);
  end else begin : g_qpsk
    assign map_i = sym_bits[0] ? IQ_W'(-A_QPSK) : IQ_W'(A_QPSK);
    assign map_q = sym_bits[1] ? IQ_W'(-A_QPSK) : IQ_W'(A_QPSK);
  end

  always_comb begin
    push_word.i   = map_i;
    push_word.q   = map_q;
    push_word.idx = sym_cnt_p0;
  end

  always_ff @(posedge ofdm_clk or negedge resetn) begin
    if (!resetn) begin
      bits_p0    <= '0;
      bit_cnt_p0 <= '0;
      sym_cnt_p0 <= '0;
    end else if (bit_acc) begin
      if (push_vld_p0) begin
        bits_p0    <= '0;
        bit_cnt_p0 <= '0;
        sym_cnt_p0 <= (sym_cnt_p0 == LAST_IDX) ? '0 : sym_cnt_p0 + 1'b1;
      end else begin
        bits_p0    <= sym_bits;
        bit_cnt_p0 <= bit_cnt_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: symbol queue and output decode ----

  ofdm_sym_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ofdm_clk),
    .resetn    (resetn),
    .push      (push_vld_p0),
    .push_data (push_word),
    .pop       (sym_vld && sym_rdy),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_word = head_data;

  // Outputs forced to zero while nothing is queued, which also gives the
  // all-zero state during reset.
  assign sym_vld = !fifo_empty;
  assign sym_i   = sym_vld ? head_word.i : '0;
  assign sym_q   = sym_vld ? head_word.q : '0;
  assign sym_idx = sym_vld ? head_word.idx : '0;
  assign sym_sof = sym_vld && (head_word.idx == '0);
  assign sym_eof = sym_vld && (head_word.idx == LAST_IDX);

endmodule

// File: tb/tb_ofdm_symbol_mapper.sv
module tb_ofdm_symbol_mapper;

  localparam int N_SC  = 48;
  localparam int IQ_W  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic                   q_vld, q_data, q_sdrdy, q_svld, q_srdy, q_sof, q_eof;
  logic signed [IQ_W-1:0] q_i, q_q;
  logic [5:0]             q_idx;

  logic                   m_vld, m_data, m_sdrdy, m_svld, m_srdy, m_sof, m_eof;
  logic signed [IQ_W-1:0] m_i, m_q;
  logic [5:0]             m_idx;

  ofdm_symbol_mapper #(
    .BITS_PER_SYM (2), .N_SC (N_SC), .IQ_W (IQ_W), .FIFO_DEPTH (DEPTH)
  ) dut_qpsk (
    .ofdm_clk (clk), .resetn (resetn),
    .ofdm_sdata_vld (q_vld), .ofdm_sdata_rdy (q_sdrdy), .ofdm_sdata (q_data),
    .sym_vld (q_svld), .sym_rdy (q_srdy), .sym_i (q_i), .sym_q (q_q),
    .sym_idx (q_idx), .sym_sof (q_sof), .sym_eof (q_eof)
  );

  ofdm_symbol_mapper #(
    .BITS_PER_SYM (4), .N_SC (N_SC), .IQ_W (IQ_W), .FIFO_DEPTH (DEPTH)
  ) dut_qam (
    .ofdm_clk (clk), .resetn (resetn),
    .ofdm_sdata_vld (m_vld), .ofdm_sdata_rdy (m_sdrdy), .ofdm_sdata (m_data),
    .sym_vld (m_svld), .sym_rdy (m_srdy), .sym_i (m_i), .sym_q (m_q),
    .sym_idx (m_idx), .sym_sof (m_sof), .sym_eof (m_eof)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the QPSK instance
  typedef struct {
    int i;
    int q;
    int idx;
  } exp_sym_t;

  exp_sym_t mq[$];
  int       m_bcnt;
  logic     m_b0;
  int       m_nidx;
  int       n_sof, n_eof;

  function automatic int qlev(input logic b);
    return b ? -64 : 64;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_bcnt = 0;
    m_b0   = 1'b0;
    m_nidx = 0;
  endtask

  task automatic do_reset();
    q_vld  = 1'b0;
    m_vld  = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_reset();
  endtask

  // One clock of the QPSK instance: check outputs against the model,
  // advance the clock, then update the model with what transferred.
  task automatic q_step(input string tag);
    logic     acc, pop, bit_in;
    exp_sym_t e;
    acc    = q_vld && q_sdrdy;
    pop    = q_svld && q_srdy;
    bit_in = q_data;
    chk({tag, "_rdy"}, q_sdrdy, (mq.size() < DEPTH) || (m_bcnt != 1));
    chk({tag, "_vld"}, q_svld, mq.size() != 0);
    if (mq.size() != 0 && q_svld === 1'b1) begin
      e = mq[0];
      chk({tag, "_i"},   q_i,   e.i);
      chk({tag, "_q"},   q_q,   e.q);
      chk({tag, "_idx"}, q_idx, e.idx);
      chk({tag, "_sof"}, q_sof, e.idx == 0);
      chk({tag, "_eof"}, q_eof, e.idx == N_SC - 1);
      if (pop && q_sof === 1'b1) n_sof++;
      if (pop && q_eof === 1'b1) n_eof++;
    end
    tick();
    if (pop && mq.size() != 0) void'(mq.pop_front());
    if (acc) begin
      if (m_bcnt == 0) begin
        m_b0   = bit_in;
        m_bcnt = 1;
      end else begin
        e.i    = qlev(m_b0);
        e.q    = qlev(bit_in);
        e.idx  = m_nidx;
        mq.push_back(e);
        m_nidx = (m_nidx + 1) % N_SC;
        m_bcnt = 0;
      end
    end
  endtask

  initial begin
    logic [7:0]  byte_v;
    logic [15:0] stream;
    int          t1_i[4], t1_q[4], t2_i[2], t2_q[2];
    int          nacc, cyc;

    t1_i = '{64, -64, -64, 64};
    t1_q = '{64, 64, -64, -64};
    t2_i = '{-96, 32};
    t2_q = '{-32, 96};

    q_vld = 0; q_data = 0; q_srdy = 0;
    m_vld = 0; m_data = 0; m_srdy = 0;
    resetn = 1'b1;
    n_sof = 0; n_eof = 0;
    model_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_q_rdy", q_sdrdy, 1);
    chk("rst_q_vld", q_svld, 0);
    chk("rst_q_i",   q_i, 0);
    chk("rst_q_q",   q_q, 0);
    chk("rst_q_idx", q_idx, 0);
    chk("rst_q_sof", q_sof, 0);
    chk("rst_q_eof", q_eof, 0);
    chk("rst_m_rdy", m_sdrdy, 1);
    chk("rst_m_vld", m_svld, 0);
    resetn = 1'b1;

    // QPSK, byte 8'hB4, sink always ready
    q_srdy = 1'b1;
    byte_v = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      q_vld  = 1'b1;
      q_data = byte_v[k];
      chk($sformatf("t1_rdy%0d", k), q_sdrdy, 1);
      tick();
      chk($sformatf("t1_vld%0d", k), q_svld, k % 2);
      if (k % 2 == 1) begin
        chk($sformatf("t1_i%0d", k / 2),   q_i,   t1_i[k / 2]);
        chk($sformatf("t1_q%0d", k / 2),   q_q,   t1_q[k / 2]);
        chk($sformatf("t1_idx%0d", k / 2), q_idx, k / 2);
        chk($sformatf("t1_sof%0d", k / 2), q_sof, k == 1);
        chk($sformatf("t1_eof%0d", k / 2), q_eof, 0);
      end
    end
    q_vld = 1'b0;
    tick();
    chk("t1_empty", q_svld, 0);

    // 16-QAM, byte 8'h1E
    m_srdy = 1'b1;
    byte_v = 8'h1E;
    for (int k = 0; k < 8; k++) begin
      m_vld  = 1'b1;
      m_data = byte_v[k];
      tick();
      chk($sformatf("t2_vld%0d", k), m_svld, (k % 4) == 3);
      if (k % 4 == 3) begin
        chk($sformatf("t2_i%0d", k / 4),   m_i,   t2_i[k / 4]);
        chk($sformatf("t2_q%0d", k / 4),   m_q,   t2_q[k / 4]);
        chk($sformatf("t2_idx%0d", k / 4), m_idx, k / 4);
      end
    end
    m_vld = 1'b0;

    // Backpressure: sink stalled, source streaming
    do_reset();
    q_srdy = 1'b0;
    q_vld  = 1'b1;
    stream = 16'h2DB4;
    nacc   = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc_now;
      q_data  = stream[nacc];
      acc_now = q_sdrdy;
      q_step("t3");
      if (acc_now) nacc++;
    end
    chk("t3_nacc",  nacc, 2 * DEPTH + 1);
    chk("t3_rdy",   q_sdrdy, 0);
    chk("t3_vld",   q_svld, 1);
    chk("t3_hold_i", q_i, 64);
    chk("t3_hold_q", q_q, 64);
    chk("t3_hold_idx", q_idx, 0);
    q_vld  = 1'b0;
    q_srdy = 1'b1;
    for (int c = 0; c < 6; c++) q_step("t3d");
    chk("t3_drained", q_svld, 0);

    // Two full frames
    do_reset();
    q_srdy = 1'b1;
    q_vld  = 1'b1;
    n_sof  = 0;
    n_eof  = 0;
    for (int c = 0; c < 4 * N_SC; c++) begin
      q_data = c[0] ^ c[2] ^ c[5];
      q_step("t4");
    end
    q_vld = 1'b0;
    for (int c = 0; c < 3; c++) q_step("t4d");
    chk("t4_sof_count", n_sof, 2);
    chk("t4_eof_count", n_eof, 2);

    // Reset with a partial symbol and queued symbols
    do_reset();
    q_srdy = 1'b0;
    stream = 16'h0004;
    for (int k = 0; k < 5; k++) begin
      q_vld  = 1'b1;
      q_data = stream[k];
      tick();
    end
    q_vld = 1'b0;
    chk("t5_queued_vld", q_svld, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_vld", q_svld, 0);
    chk("t5_rst_rdy", q_sdrdy, 1);
    chk("t5_rst_sof", q_sof, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q_srdy = 1'b1;
    q_vld  = 1'b1;
    q_data = 1'b1;
    tick();
    chk("t5_vld_1bit", q_svld, 0);
    tick();
    q_vld = 1'b0;
    chk("t5_vld", q_svld, 1);
    chk("t5_i",   q_i, -64);
    chk("t5_q",   q_q, -64);
    chk("t5_idx", q_idx, 0);
    chk("t5_sof", q_sof, 1);
    tick();
    chk("t5_after", q_svld, 0);

    // Random gaps on both sides
    do_reset();
    nacc = 0;
    cyc  = 0;
    while (nacc < 10000 && cyc < 60000) begin
      q_vld  = ($urandom_range(0, 99) < 70);
      q_data = $urandom_range(0, 1);
      q_srdy = ($urandom_range(0, 99) < 60);
      if (q_vld && q_sdrdy) nacc++;
      q_step("t6");
      cyc++;
    end
    q_vld  = 1'b0;
    q_srdy = 1'b1;
    for (int c = 0; c < 8; c++) q_step("t6d");
    chk("t6_bits", nacc, 10000);
    chk("t6_drained", q_svld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
